iir_biquad_wb_mc: RTL and testbench
===================================

// Module: iir_biquad_wb_mc
// PURPOSE
//  Multi-channel, coefficient-programmable IIR biquad (Direct Form I) behind a Wishbone classic slave.
//  It replaces the fixed single-channel iir_wishbone block: NUM_CH channels share one coefficient set
//  and one time-multiplexed MAC engine. Channel history is kept per channel. Outputs saturate and
//  raise a sticky overflow flag. Wait states keep any Y read coherent with the last X write.
// PARAMETERS
//  DATA_WIDTH    32  Wishbone data bus width
//  ADDR_WIDTH    8   Wishbone byte-address width (must be >=7)
//  SAMPLE_WIDTH  16  signed sample width (<= DATA_WIDTH)
//  COEF_WIDTH    18  signed coefficient width
//  FRAC_BITS     14  fractional bits of coefficients (Q format)
//  NUM_CH        4   channel count, 1..8
// PORTS
//  wb_clk_i   in   1             clock; all logic rising-edge
//  wb_rst_n_i in   1             reset, asynchronous assert, active-low
//  wb_adr_i   in   ADDR_WIDTH    byte address; bits[1:0] ignored
//  wb_dat_i   in   DATA_WIDTH    write data
//  wb_dat_o   out  DATA_WIDTH    read data, valid while wb_ack_o=1
//  wb_we_i    in   1             1=write
//  wb_stb_i   in   1             strobe
//  wb_cyc_i   in   1             cycle
//  wb_ack_o   out  1             single-cycle registered acknowledge
// BEHAVIOUR
//  Map: 0x00 CTRL [0]EN rw (reset 1), [1]CLR write-1 self-clearing | 0x04 STATUS [0]BUSY ro,
//   [1]OVF sticky W1C | 0x08 B0, 0x0C B1, 0x10 B2, 0x14 A1, 0x18 A2 (COEF_WIDTH bits, sign-extended on read)
//   | 0x20+4*ch X_ch (write; reads return 0) | 0x40+4*ch Y_ch (ro, sign-extended).
//   Unmapped or ch>=NUM_CH: acked; reads return 0; writes are ignored.
//  Reset: ack=0, dat_o=0, FSM IDLE, all history/Y=0, OVF=0, EN=1, B0=1<<FRAC_BITS, other coefs 0 (passthrough).
//  Ack: wb_ack_o <= stb&cyc&~ack&~stall. It is deasserted the cycle after. A transfer is held while stall=1.
//  Stall: any write while BUSY, or a Y read while BUSY. STATUS/CTRL/coef reads never stall.
//  X write with EN=1: on the ack edge, latch sample=dat_i[SAMPLE_WIDTH-1:0] and the channel, then go to MAC.
//   With EN=0: acked; the sample is discarded and state is unchanged.
//  FSM IDLE->MAC(k=0..4)->WB->IDLE. BUSY=1 in MAC and WB.
//   MAC k terms: b0*x, b1*x1, b2*x2, -a1*y1, -a2*y2. The accumulator is cleared at k=0.
//   WB: y=sat(acc>>>FRAC_BITS) using an arithmetic shift (truncate toward -inf).
//   WB also shifts x2<=x1, x1<=x, y2<=y1, y1<=y, and sets Y_ch=y.
//  Latency: Y_ch updated 6 cycles after the X ack edge. The earliest next write acks on cycle 7.
//  Widths: products are COEF_WIDTH+SAMPLE_WIDTH. The accumulator is that width +3 guard bits.
//   Saturation clamps to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1] and sets OVF. Saturated y is stored in history.
//  CLR (taken only when IDLE): zeros history and Y for all channels in one cycle. Coefs and EN are unchanged.
//  Simultaneous OVF set by the engine and a W1C write in the same cycle: set wins.
//  Coef writes take effect on the next sample. They are never applied mid-MAC because writes stall while BUSY.
//  Reset mid-transfer or mid-MAC: everything returns to reset values immediately. The in-flight sample is lost.
// TESTING (defaults; coef hex = Q14)
//  1 After reset: X0<=1234 then read Y0 -> 1234; STATUS=0; the Y0 read ack is >=6 cycles after the X ack.
//  2 B0=0x2000,B1=0x2000: X1<=100,200 -> Y1=50,150; Y0 and Y2 unchanged (channel isolation).
//  3 B0=0x4000,A1=0x3E000 (-0.5): X2<=1000,0,0 -> Y2=1000,500,250; CLR -> Y2=0; next X2<=0 -> Y2=0.
//  4 B0=0x8000 (2.0): X0<=30000 -> Y0=32767, OVF=1; X0<=-30000 -> Y0=-32768; write 0x2 to STATUS -> OVF=0.
//  5 Stall: issue X3 write during BUSY -> ack withheld until IDLE. EN=0 then X3<=77 -> Y3 unchanged.
//  6 Drop wb_rst_n_i low during MAC k=2 -> ack=0, BUSY=0, all Y=0, B0 reads 0x4000, EN=1.

Source files
------------

// File: rtl/iir_biquad_wb_mc.sv
// iir_biquad_wb_mc: multi-channel Direct Form I biquad with a shared MAC engine behind a Wishbone classic slave
module iir_biquad_wb_mc #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int SAMPLE_WIDTH = 16,
    parameter int COEF_WIDTH   = 18,
    parameter int FRAC_BITS    = 14,
    parameter int NUM_CH       = 4
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_n_i,
    input  logic [ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    input  logic                  wb_we_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_cyc_i,
    output logic                  wb_ack_o
);
    localparam int PW = COEF_WIDTH + SAMPLE_WIDTH;
    localparam int AW = PW + 3;
    localparam logic [COEF_WIDTH-1:0] UNITY = {{(COEF_WIDTH-1){1'b0}}, 1'b1} << FRAC_BITS;

    typedef enum logic [1:0] {IDLE, MAC, WB} state_t;
    state_t state, state_nx;
    logic [2:0] k;
    logic busy, mac_on, wb_on;

    logic en, ovf;
    logic signed [COEF_WIDTH-1:0] b0, b1, b2, a1, a2;
    logic signed [SAMPLE_WIDTH-1:0] x1 [8];
    logic signed [SAMPLE_WIDTH-1:0] x2 [8];
    logic signed [SAMPLE_WIDTH-1:0] y1 [8];
    logic signed [SAMPLE_WIDTH-1:0] y2 [8];
    logic signed [SAMPLE_WIDTH-1:0] xs;
    logic [2:0] ch;

    logic [4:0] w;
    logic [2:0] wc;
    logic hi_ok, ch_ok, is_x, is_y, stall, go, wr, start, clr;
    logic [DATA_WIDTH-1:0] rdata;

    logic signed [COEF_WIDTH-1:0] coef_m;
    logic signed [SAMPLE_WIDTH-1:0] op_m, y_sat;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] acc, acc_nx, sh;
    logic ovf_w;

    logic unused_ok;
    assign unused_ok = &{1'b0, wb_dat_i, wb_adr_i[1:0]};

    // address decode and transfer qualification
    always_comb begin
        w     = wb_adr_i[6:2];
        wc    = w[2:0];
        hi_ok = (wb_adr_i >> 7) == '0;
        ch_ok = int'(wc) < NUM_CH;
        is_x  = hi_ok && w[4:3] == 2'b01 && ch_ok;
        is_y  = hi_ok && w[4:3] == 2'b10 && ch_ok;
        stall = busy && (wb_we_i || is_y);
        go    = wb_stb_i && wb_cyc_i && !wb_ack_o && !stall;
        wr    = go && wb_we_i;
        start = wr && is_x && en;
        clr   = wr && hi_ok && w == 5'd0 && wb_dat_i[1] && !busy;
    end

    // read data mux
    always_comb begin
        rdata = '0;
        if (hi_ok)
            case (w)
                5'd0:    rdata = DATA_WIDTH'(en);
                5'd1:    rdata = DATA_WIDTH'({ovf, busy});
                5'd2:    rdata = DATA_WIDTH'(b0);
                5'd3:    rdata = DATA_WIDTH'(b1);
                5'd4:    rdata = DATA_WIDTH'(b2);
                5'd5:    rdata = DATA_WIDTH'(a1);
                5'd6:    rdata = DATA_WIDTH'(a2);
                default: rdata = is_y ? DATA_WIDTH'(y1[wc]) : '0;
            endcase
    end

    // registered single-cycle acknowledge and read data
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= go;
            wb_dat_o <= (go && !wb_we_i) ? rdata : '0;
        end
    end

    // control, status and coefficient registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            en  <= 1'b1;
            ovf <= 1'b0;
            b0  <= UNITY;
            b1  <= '0;
            b2  <= '0;
            a1  <= '0;
            a2  <= '0;
        end else begin
            ovf <= (wb_on && ovf_w) || (ovf && !(wr && hi_ok && w == 5'd1 && wb_dat_i[1]));
            if (wr && hi_ok)
                case (w)
                    5'd0:    en <= wb_dat_i[0];
                    5'd2:    b0 <= wb_dat_i[COEF_WIDTH-1:0];
                    5'd3:    b1 <= wb_dat_i[COEF_WIDTH-1:0];
                    5'd4:    b2 <= wb_dat_i[COEF_WIDTH-1:0];
                    5'd5:    a1 <= wb_dat_i[COEF_WIDTH-1:0];
                    5'd6:    a2 <= wb_dat_i[COEF_WIDTH-1:0];
                    default: ;
                endcase
        end
    end

    // FSM state register and MAC term counter
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state <= IDLE;
            k     <= 3'd0;
        end else begin
            state <= state_nx;
            k     <= (state == MAC && k != 3'd4) ? k + 3'd1 : 3'd0;
        end
    end

    // FSM next state
    always_comb begin
        state_nx = state == IDLE ? (start ? MAC : IDLE) :
                   state == MAC  ? (k == 3'd4 ? WB : MAC) : IDLE;
    end

    // FSM outputs
    always_comb begin
        busy   = state != IDLE;
        mac_on = state == MAC;
        wb_on  = state == WB;
    end

    // one MAC term per cycle; feedback terms are subtracted
    always_comb begin
        coef_m = k == 3'd0 ? b0 : k == 3'd1 ? b1 : k == 3'd2 ? b2 : k == 3'd3 ? a1 : a2;
        op_m   = k == 3'd0 ? xs : k == 3'd1 ? x1[ch] : k == 3'd2 ? x2[ch] : k == 3'd3 ? y1[ch] : y2[ch];
        prod   = PW'(coef_m) * PW'(op_m);
        acc_nx = k == 3'd0 ? AW'(prod) : k >= 3'd3 ? acc - AW'(prod) : acc + AW'(prod);
        sh     = acc >>> FRAC_BITS;
        ovf_w  = !(&sh[AW-1:SAMPLE_WIDTH-1] || !(|sh[AW-1:SAMPLE_WIDTH-1]));
        y_sat  = ovf_w ? {sh[AW-1], {(SAMPLE_WIDTH-1){~sh[AW-1]}}} : sh[SAMPLE_WIDTH-1:0];
    end

    // sample capture, accumulator and per-channel history
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            xs  <= '0;
            ch  <= 3'd0;
            acc <= '0;
            for (int i = 0; i < 8; i++) begin
                x1[i] <= '0;
                x2[i] <= '0;
                y1[i] <= '0;
                y2[i] <= '0;
            end
        end else begin
            if (start) begin
                xs <= wb_dat_i[SAMPLE_WIDTH-1:0];
                ch <= wc;
            end
            if (mac_on)
                acc <= acc_nx;
            if (wb_on) begin
                x2[ch] <= x1[ch];
                x1[ch] <= xs;
                y2[ch] <= y1[ch];
                y1[ch] <= y_sat;
            end
            if (clr)
                for (int i = 0; i < 8; i++) begin
                    x1[i] <= '0;
                    x2[i] <= '0;
                    y1[i] <= '0;
                    y2[i] <= '0;
                end
        end
    end
endmodule

// File: tb/tb_iir_biquad_wb_mc.sv
// tb_iir_biquad_wb_mc: scoreboard bench for the multi-channel Wishbone biquad
module tb_iir_biquad_wb_mc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  adr = '0;
    logic [31:0] dati = '0;
    logic [31:0] dato;
    logic        we = 1'b0, stb = 1'b0, cyc = 1'b0;
    logic        ack;
    int total = 0, bad = 0, cyc_n = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    iir_biquad_wb_mc dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_adr_i(adr), .wb_dat_i(dati),
        .wb_dat_o(dato), .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_ack_o(ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // monitor: every read acknowledge is checked against the oldest expectation
    always @(negedge clk) begin
        if (ack && !we) begin
            total = total + 1;
            if (sbq.size() == 0) begin
                bad = bad + 1;
                $display("FAIL unexpected_read got=%h required=none", dato);
            end else begin
                mon_e = sbq.pop_front();
                if (dato !== mon_e.exp) begin
                    bad = bad + 1;
                    $display("FAIL %s got=%h required=%h", mon_e.name, dato, mon_e.exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] a, input logic w, input logic [31:0] d, output int t);
        adr = a; we = w; dati = d; stb = 1'b1; cyc = 1'b1; t = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                t = cyc_n;
                break;
            end
        end
        stb = 1'b0; cyc = 1'b0;
        if (t < 0) begin
            total = total + 1;
            bad = bad + 1;
            $display("FAIL xfer_timeout adr=%h got=no_ack required=ack", a);
            if (!w && sbq.size() > 0) void'(sbq.pop_back());
        end
        @(negedge clk); #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        int t;
        xfer(a, 1'b1, d, t);
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] e, input string name);
        exp_t x;
        int t;
        x.name = name;
        x.exp = e;
        sbq.push_back(x);
        xfer(a, 1'b0, 32'h0, t);
    endtask

    initial begin
        int t0, t1;
        exp_t x;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ack", {31'b0, ack}, 32'h0);
        chk("reset_dat", dato, 32'h0);
        @(negedge clk); rst_n = 1'b1; #1;

        // 1: passthrough after reset, read latency
        rd(8'h00, 32'h1, "ctrl_reset");
        rd(8'h08, 32'h4000, "b0_reset");
        xfer(8'h20, 1'b1, 32'd1234, t0);
        x.name = "y0_pass"; x.exp = 32'd1234; sbq.push_back(x);
        xfer(8'h40, 1'b0, 32'h0, t1);
        chk("y_read_latency_ge6", {31'b0, (t1 - t0) >= 6}, 32'h1);
        rd(8'h04, 32'h0, "status_idle");

        // 2: half-gain FIR on channel 1, isolation
        wr(8'h08, 32'h2000); wr(8'h0C, 32'h2000);
        wr(8'h24, 32'd100); rd(8'h44, 32'd50, "y1_first");
        wr(8'h24, 32'd200); rd(8'h44, 32'd150, "y1_second");
        rd(8'h40, 32'd1234, "y0_isolated");
        rd(8'h48, 32'h0, "y2_isolated");

        // 3: feedback pole at 0.5, CLR
        wr(8'h08, 32'h4000); wr(8'h0C, 32'h0); wr(8'h14, 32'h3E000);
        rd(8'h14, 32'hFFFFE000, "a1_signext");
        wr(8'h28, 32'd1000); rd(8'h48, 32'd1000, "y2_imp0");
        wr(8'h28, 32'd0);    rd(8'h48, 32'd500,  "y2_imp1");
        wr(8'h28, 32'd0);    rd(8'h48, 32'd250,  "y2_imp2");
        wr(8'h00, 32'h3);
        rd(8'h48, 32'h0, "y2_after_clr");
        rd(8'h00, 32'h1, "ctrl_after_clr");
        wr(8'h28, 32'd0);    rd(8'h48, 32'h0, "y2_hist_cleared");

        // 4: saturation and sticky overflow
        wr(8'h14, 32'h0); wr(8'h08, 32'h8000);
        wr(8'h20, 32'd30000);   rd(8'h40, 32'h7FFF, "y0_sat_pos");
        rd(8'h04, 32'h2, "status_ovf");
        wr(8'h20, 32'hFFFF8AD0); rd(8'h40, 32'hFFFF8000, "y0_sat_neg");
        wr(8'h04, 32'h2);
        rd(8'h04, 32'h0, "status_ovf_w1c");

        // unmapped and out-of-range channel accesses
        rd(8'h1C, 32'h0, "unmapped_read");
        rd(8'h20, 32'h0, "x_read_zero");
        rd(8'h50, 32'h0, "y_ch4_zero");
        wr(8'h30, 32'd55);
        rd(8'h04, 32'h0, "x_ch4_no_busy");
        wr(8'h08, 32'h4000);
        wr(8'h5C, 32'h1);
        rd(8'h08, 32'h4000, "unmapped_write_ignored");

        // 5: stall and EN=0
        xfer(8'h2C, 1'b1, 32'd5, t0);
        xfer(8'h2C, 1'b1, 32'd6, t1);
        chk("write_stall_cycles", t1 - t0, 32'd7);
        rd(8'h4C, 32'd6, "y3_after_stall");
        wr(8'h00, 32'h0);
        wr(8'h2C, 32'd77);
        rd(8'h4C, 32'd6, "y3_en_off");
        rd(8'h00, 32'h0, "ctrl_en_off");
        wr(8'h00, 32'h1);

        // 6: asynchronous reset while the engine is at term k=2
        wr(8'h08, 32'h8000); wr(8'h0C, 32'h1234);
        wr(8'h20, 32'd100);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0; #1;
        chk("midmac_reset_ack", {31'b0, ack}, 32'h0);
        chk("midmac_reset_dat", dato, 32'h0);
        @(negedge clk); rst_n = 1'b1; #1;
        rd(8'h04, 32'h0, "status_after_reset");
        rd(8'h40, 32'h0, "y0_after_reset");
        rd(8'h44, 32'h0, "y1_after_reset");
        rd(8'h48, 32'h0, "y2_after_reset");
        rd(8'h4C, 32'h0, "y3_after_reset");
        rd(8'h08, 32'h4000, "b0_after_reset");
        rd(8'h0C, 32'h0, "b1_after_reset");
        rd(8'h00, 32'h1, "ctrl_after_reset");

        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
        if (sbq.size() > 0) begin
            $display("FAIL pending_reads got=%0d required=0", sbq.size());
            total = total + 1;
            bad = bad + 1;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
